booth_mult_seq: RTL and testbench
=================================

Name: booth_mult_seq

Overview:
- Sequential 32x32 signed (two's-complement) multiplier built around one shared CSA_32b carry-select adder, instantiated internally.
- Performs a radix-2 Booth algorithm with one add, subtract or skip step per cycle, 32 iterations per operation.
- Sits beside the ALU as the multi-cycle multiply unit, with valid/ready handshakes on both the operand side and the result side.

Parameters:
- N_ITER, 32, number of Booth iterations; fixed by the 32-bit operand width, not user-tunable.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  unit can accept operands.
- op_a  in  32  multiplicand M, signed.
- op_b  in  32  multiplier Q, signed.
- cancel  in  1  synchronous abort of the operation in flight.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- p_hi  out  32  product bits [63:32].
- p_lo  out  32  product bits [31:0].
- busy  out  1  high in RUN.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; A, Q, M, q_m1 and count cleared to 0.
  - out_valid=0, busy=0, in_ready=1, p_hi=p_lo=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: M<=op_a, Q<=op_b, A<=0, q_m1<=0, count<=0, go to RUN.
- RUN: busy=1, in_ready=0. Each edge performs one iteration:
  - {Q[0],q_m1}=01: A+M. 10: A+~M with cin=1. 00 or 11: A unchanged. The adder is used for the add and subtract cases.
  - Arithmetic shift right of {A',Q,q_m1} by 1. The bit shifted into A[31] is sum[31] XOR signed-overflow(A, operand), so the true sign is preserved when M = 0x80000000.
  - count increments. The edge with count=31 moves to DONE.
- Latency: out_valid rises exactly 32 edges after the accept edge.
- DONE:
  - out_valid=1; p_hi=A, p_lo=Q, held stable.
  - Edge with out_ready=1 goes to IDLE with out_valid=0. in_ready returns the following cycle; no accept in the same cycle as the release.
- Backpressure: out_ready=0 holds DONE and the outputs indefinitely. in_valid is ignored outside IDLE.
- cancel:
  - In RUN: the next edge returns to IDLE; out_valid never asserts; registers keep their values, but p_hi/p_lo are don't-care until the next DONE.
  - In IDLE: has priority over in_valid, so no accept.
  - In DONE: drops the result and goes to IDLE.
- reset_n asserted mid-RUN or mid-DONE: immediate return to the reset values; no partial result is exposed.
- Operands are sampled only on the accept edge; later changes to op_a/op_b have no effect.
- Adder instance fixed at 32 bits; cin is 0 for add and 1 for subtract.

Optional Feature:
- Macro: MULT_OVF_EN.
- Defined:
  - Adds output data_exception (1 bit), valid with out_valid.
  - data_exception=1 when p_hi differs from the 32-fold replication of p_lo[31], meaning the product does not fit in 32 signed bits.
  - Reset value 0; cleared on leaving DONE.
- Not defined: port absent, no overflow logic.

Test Plan:
- 3 x 5 accepted at t0 -> out_valid exactly 32 edges later; p_hi=0x00000000, p_lo=0x0000000F.
- -7 x 6 -> p_hi=0xFFFFFFFF, p_lo=0xFFFFFFD6.
- 0x80000000 x 0x80000000 -> p_hi=0x40000000, p_lo=0x00000000; with MULT_OVF_EN, data_exception=1. Also 0x7FFFFFFF x 0x80000000 -> p_hi=0xC0000000, p_lo=0x80000000.
- 1234 x -1 with out_ready=0 for 10 cycles after out_valid -> outputs held at 0xFFFFFB2E (p_lo) and 0xFFFFFFFF (p_hi); in_ready=0 throughout; in_valid pulses are ignored.
- cancel at iteration 10, then 2 x 2 -> no out_valid for the first operation; second returns p_lo=4, p_hi=0, 32 edges after its accept.
- reset_n low at iteration 20 -> all outputs at reset values immediately; after release, in_ready=1 and 0 x 0x12345678 returns 0/0.

Source files
------------

// File: rtl/booth_mult_seq_if.sv
// Handshake and data bundle for booth_mult_seq.
// The data_exception signal exists only when MULT_OVF_EN is defined.
interface booth_mult_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        cancel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  logic        busy;
`ifdef MULT_OVF_EN
  logic        data_exception;

  modport master (
    output in_valid, op_a, op_b, cancel, out_ready,
    input  in_ready, out_valid, p_hi, p_lo, busy, data_exception
  );

  modport slave (
    input  in_valid, op_a, op_b, cancel, out_ready,
    output in_ready, out_valid, p_hi, p_lo, busy, data_exception
  );
`else
  modport master (
    output in_valid, op_a, op_b, cancel, out_ready,
    input  in_ready, out_valid, p_hi, p_lo, busy
  );

  modport slave (
    input  in_valid, op_a, op_b, cancel, out_ready,
    output in_ready, out_valid, p_hi, p_lo, busy
  );
`endif
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential 32x32 signed radix-2 Booth multiplier.
// One add/subtract/skip step per cycle through a shared 32-bit carry-select
// adder, 32 iterations per operation, valid/ready on operand and result sides.
// Optional macro MULT_OVF_EN adds data_exception (product does not fit in
// 32 signed bits).

// 32-bit carry-select adder: low half ripples, high half precomputed for both
// carry-in values and selected by the low-half carry.
module CSA_32b (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [16:0] lo_sum;
  logic [16:0] hi_sum0;
  logic [16:0] hi_sum1;

  // Both high-half candidates computed in parallel with the low half
  always_comb begin
    lo_sum  = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'd0, cin};
    hi_sum0 = {1'b0, a[31:16]} + {1'b0, b[31:16]};
    hi_sum1 = {1'b0, a[31:16]} + {1'b0, b[31:16]} + 17'd1;
    sum     = {(lo_sum[16] ? hi_sum1[15:0] : hi_sum0[15:0]), lo_sum[15:0]};
    cout    = lo_sum[16] ? hi_sum1[16] : hi_sum0[16];
  end
endmodule

module booth_mult_seq (
  input  logic             clock,
  input  logic             reset_n,
  booth_mult_seq_if.slave  bus
);
  localparam int unsigned N_ITER    = 32;
  localparam logic [4:0]  LAST_ITER = 5'(N_ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e      state_q,     state_d;
  logic [31:0] a_q,         a_d;
  logic [31:0] q_q,         q_d;
  logic [31:0] m_q,         m_d;
  logic        qm1_q,       qm1_d;
  logic [4:0]  count_q,     count_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q,      busy_d;
  logic        in_ready_q,  in_ready_d;
  logic [31:0] p_hi_q,      p_hi_d;
  logic [31:0] p_lo_q,      p_lo_d;
`ifdef MULT_OVF_EN
  logic        exc_q,       exc_d;
`endif

  logic        do_add;
  logic        do_sub;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;

  // Booth recoding of {Q[0], q_m1} selects +M, -M (~M + 1) or skip
  always_comb begin
    do_add  = ({q_q[0], qm1_q} == 2'b01);
    do_sub  = ({q_q[0], qm1_q} == 2'b10);
    add_b   = do_sub ? ~m_q : m_q;
    add_cin = do_sub;
  end

  CSA_32b u_adder (
    .a    (a_q),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  logic        carry_msb;
  logic        ovf;
  logic [31:0] a_pre;
  logic        a_top;

  // Next-state and datapath for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    q_d         = q_q;
    m_d         = m_q;
    qm1_d       = qm1_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    in_ready_d  = in_ready_q;
    p_hi_d      = p_hi_q;
    p_lo_d      = p_lo_q;
`ifdef MULT_OVF_EN
    exc_d       = exc_q;
`endif
    // Sign of the 33-bit true sum is sum[31] ^ overflow; overflow is the
    // carry into bit 31 differing from the carry out. This keeps the shifted-in
    // sign correct when M = 0x80000000 without widening A.
    carry_msb = add_sum[31] ^ a_q[31] ^ add_b[31];
    ovf       = carry_msb ^ add_cout;
    a_pre     = (do_add || do_sub) ? add_sum : a_q;
    a_top     = (do_add || do_sub) ? (add_sum[31] ^ ovf) : a_q[31];

    unique case (state_q)
      S_IDLE: begin
        if (!bus.cancel && bus.in_valid) begin
          m_d        = bus.op_a;
          q_d        = bus.op_b;
          a_d        = '0;
          qm1_d      = 1'b0;
          count_d    = '0;
          state_d    = S_RUN;
          busy_d     = 1'b1;
          in_ready_d = 1'b0;
        end
      end
      S_RUN: begin
        if (bus.cancel) begin
          state_d    = S_IDLE;
          busy_d     = 1'b0;
          in_ready_d = 1'b1;
        end else begin
          a_d     = {a_top, a_pre[31:1]};
          q_d     = {a_pre[0], q_q[31:1]};
          qm1_d   = q_q[0];
          count_d = 5'(count_q + 5'd1);
          if (count_q == LAST_ITER) begin
            state_d     = S_DONE;
            busy_d      = 1'b0;
            out_valid_d = 1'b1;
            p_hi_d      = a_d;
            p_lo_d      = q_d;
`ifdef MULT_OVF_EN
            exc_d       = (a_d != {32{q_d[31]}});
`endif
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready || bus.cancel) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
`ifdef MULT_OVF_EN
          exc_d       = 1'b0;
`endif
        end
      end
      default: begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and registered outputs, asynchronously cleared
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      qm1_q       <= 1'b0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      p_hi_q      <= '0;
      p_lo_q      <= '0;
`ifdef MULT_OVF_EN
      exc_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      m_q         <= m_d;
      qm1_q       <= qm1_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      p_hi_q      <= p_hi_d;
      p_lo_q      <= p_lo_d;
`ifdef MULT_OVF_EN
      exc_q       <= exc_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.p_hi      = p_hi_q;
  assign bus.p_lo      = p_lo_q;
`ifdef MULT_OVF_EN
  assign bus.data_exception = exc_q;
`endif
endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed testbench for booth_mult_seq with hand-computed products.
module tb_booth_mult_seq;
  logic clock;
  logic reset_n;
  int unsigned n_checks;
  int unsigned n_fail;

  booth_mult_seq_if bus ();

  booth_mult_seq dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for in_ready, present operands, and return just after the accept edge
  task automatic start_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    int unsigned waited;
    waited = 0;
    @(negedge clock);
    while (!bus.in_ready && waited < 10) begin
      @(negedge clock);
      waited++;
    end
    check_eq({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.op_a     = a;
    bus.op_b     = b;
    bus.in_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.op_a     = 32'hDEAD_BEEF;
    bus.op_b     = 32'hCAFE_F00D;
    check_eq({tag, "_busy"}, 64'(bus.busy), 64'd1);
  endtask

  // Count edges after accept until out_valid is seen (bounded)
  task automatic wait_done(output int unsigned edges);
    edges = 0;
    while (edges < 100) begin
      @(posedge clock);
      edges++;
      #1;
      if (bus.out_valid) break;
    end
  endtask

  task automatic release_result(input string tag);
    @(negedge clock);
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
    check_eq({tag, "_rel_valid"}, 64'(bus.out_valid), 64'd0);
    check_eq({tag, "_rel_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic run_and_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int unsigned edges;
    start_op(tag, a, b);
    wait_done(edges);
    check_eq({tag, "_latency"}, 64'(edges), 64'd32);
    check_eq({tag, "_p_hi"}, 64'(bus.p_hi), 64'(exp_hi));
    check_eq({tag, "_p_lo"}, 64'(bus.p_lo), 64'(exp_lo));
`ifdef MULT_OVF_EN
    check_eq({tag, "_exc"}, 64'(bus.data_exception),
             64'(exp_hi != {32{exp_lo[31]}}));
`endif
    release_result(tag);
  endtask

  initial begin
    int unsigned edges;
    logic        saw_valid;
    n_checks      = 0;
    n_fail        = 0;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.cancel    = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clock);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_busy",      64'(bus.busy),      64'd0);
    check_eq("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check_eq("rst_p_hi",      64'(bus.p_hi),      64'd0);
    check_eq("rst_p_lo",      64'(bus.p_lo),      64'd0);
    reset_n = 1'b1;

    run_and_check("m3x5",    32'd3,          32'd5,          32'h0000_0000, 32'h0000_000F);
    run_and_check("mn7x6",   32'hFFFF_FFF9,  32'd6,          32'hFFFF_FFFF, 32'hFFFF_FFD6);
    run_and_check("minxmin", 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000);
    run_and_check("maxxmin", 32'h7FFF_FFFF,  32'h8000_0000,  32'hC000_0000, 32'h8000_0000);

    // Backpressure: hold result 10 cycles, in_valid pulses must be ignored
    start_op("bp", 32'd1234, 32'hFFFF_FFFF);
    wait_done(edges);
    check_eq("bp_latency", 64'(edges), 64'd32);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      bus.in_valid = i[0];
      bus.op_a     = 32'd99;
      bus.op_b     = 32'd77;
      check_eq("bp_p_lo",      64'(bus.p_lo),      64'hFFFF_FB2E);
      check_eq("bp_p_hi",      64'(bus.p_hi),      64'hFFFF_FFFF);
      check_eq("bp_in_ready",  64'(bus.in_ready),  64'd0);
      check_eq("bp_out_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.in_valid = 1'b0;
    release_result("bp");
    @(negedge clock);
    check_eq("bp_no_accept", 64'(bus.busy), 64'd0);

    // cancel in IDLE has priority over in_valid
    @(negedge clock);
    bus.cancel   = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.cancel   = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("idle_cancel_busy",  64'(bus.busy),     64'd0);
    check_eq("idle_cancel_ready", 64'(bus.in_ready), 64'd1);

    // cancel at iteration 10, then a fresh operation
    start_op("cxl", 32'd7, 32'd9);
    repeat (10) @(posedge clock);
    @(negedge clock);
    bus.cancel = 1'b1;
    @(posedge clock);
    #1;
    bus.cancel = 1'b0;
    check_eq("cxl_busy",     64'(bus.busy),     64'd0);
    check_eq("cxl_in_ready", 64'(bus.in_ready), 64'd1);
    saw_valid = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (bus.out_valid) saw_valid = 1'b1;
    end
    check_eq("cxl_no_valid", 64'(saw_valid), 64'd0);
    run_and_check("m2x2", 32'd2, 32'd2, 32'h0000_0000, 32'h0000_0004);

    // Asynchronous reset at iteration 20
    start_op("rst20", 32'h55, 32'h77);
    repeat (20) @(posedge clock);
    @(negedge clock);
    check_eq("rst20_busy_pre", 64'(bus.busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check_eq("rst20_busy",      64'(bus.busy),      64'd0);
    check_eq("rst20_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst20_in_ready",  64'(bus.in_ready),  64'd1);
    check_eq("rst20_p_hi",      64'(bus.p_hi),      64'd0);
    check_eq("rst20_p_lo",      64'(bus.p_lo),      64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_eq("rst20_ready_after", 64'(bus.in_ready), 64'd1);
    run_and_check("m0xk", 32'd0, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
